// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM duty-code decoder with period policing and lock status
//
// Purpose: measures the high time and rise-to-rise period of an asynchronous
// PWM line, publishes a rounded 4-bit duty code for each in-tolerance frame,
// flags malformed frames, and reports a 0 code when the line stays low.
//
// Ports:
//   clk_1MHz    in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pwm_in      in   asynchronous PWM line, high phase first
//   pulse_width out  [3:0] decoded duty code (registered)
//   valid       out  one-cycle strobe: pulse_width updated
//   frame_err   out  one-cycle strobe: malformed frame
//   locked      out  good frame decoded since the last error
module pwm_decoder #(
  parameter int UNIT  = 100,
  parameter int FRAME = 2000,
  parameter int TOL   = 50
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [3:0] pulse_width,
  output logic       valid,
  output logic       frame_err,
  output logic       locked
);

  // Cycle count that means "too long": stuck high or no rise at all.
  localparam int LIMIT = FRAME + TOL + 1;
  // At least 11 bits, widened when needed so LIMIT itself is representable.
  localparam int CNT_W = ($clog2(LIMIT + 1) > 11) ? $clog2(LIMIT + 1) : 11;

  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(FRAME - TOL);
  localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(FRAME + TOL);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LOW   = 2'd3;

  logic             sync1_q, sync2_q, sync3_q;
  logic [1:0]       fill_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [3:0]       pw_q, pw_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  logic             rise, fall;
  logic [CNT_W-1:0] high_inc, per_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [3:0] round_code(input logic [CNT_W-1:0] h);
    logic [CNT_W:0] sum;
    logic [CNT_W:0] q;
    sum = {1'b0, h} + (CNT_W+1)'(UNIT / 2);
    q   = sum / (CNT_W+1)'(UNIT);
    return (q > (CNT_W+1)'(15)) ? 4'd15 : q[3:0];
  endfunction

  assign rise     = sync2_q & ~sync3_q;
  assign fall     = ~sync2_q & sync3_q;
  assign high_inc = sat_inc(high_q);
  assign per_inc  = sat_inc(per_q);

  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    per_d    = per_q;
    pw_d     = pw_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;

    case (state_q)
      S_IDLE: begin
        // fill_q keeps stale post-reset zeros in the synchronizer from
        // looking like a real low phase.
        if (fill_q == 2'd3 && !sync2_q) begin
          state_d = S_ARMED;
          high_d  = '0;
          per_d   = CNT_ONE;
        end
      end

      S_ARMED: begin
        if (rise) begin
          state_d = S_HIGH;
          high_d  = CNT_ONE;
          per_d   = CNT_ONE;
        end else if (per_q == CNT_LIM) begin
          // Line idle for a whole over-long frame: duty is zero.
          valid_d = 1'b1;
          pw_d    = 4'd0;
          per_d   = CNT_ONE;
        end else begin
          per_d = per_inc;
        end
      end

      S_HIGH: begin
        per_d = per_inc;
        if (fall) begin
          // high_cnt is not bumped here so it equals the exact high time.
          state_d = S_LOW;
        end else if (high_inc == CNT_LIM) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = S_IDLE;
          high_d   = '0;
          per_d    = '0;
        end else begin
          high_d = high_inc;
        end
      end

      S_LOW: begin
        if (rise) begin
          // per_q holds the exact rise-to-rise distance in this cycle.
          if (per_q >= PER_MIN && per_q <= PER_MAX) begin
            pw_d     = round_code(high_q);
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
          state_d = S_HIGH;
          high_d  = CNT_ONE;
          per_d   = CNT_ONE;
        end else if (per_q == CNT_LIM) begin
          valid_d = 1'b1;
          pw_d    = 4'd0;
          per_d   = CNT_ONE;
          state_d = S_ARMED;
        end else begin
          per_d = per_inc;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      fill_q   <= 2'd0;
      state_q  <= S_IDLE;
      high_q   <= '0;
      per_q    <= '0;
      pw_q     <= 4'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      sync1_q  <= pwm_in;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      if (fill_q != 2'd3) begin
        fill_q <= fill_q + 2'd1;
      end
      state_q  <= state_d;
      high_q   <= high_d;
      per_q    <= per_d;
      pw_q     <= pw_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign pulse_width = pw_q;
  assign valid       = valid_q;
  assign frame_err   = err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - scoreboard testbench for pwm_decoder
`timescale 1ns/1ps
module tb_pwm_decoder;

  localparam int UNIT  = 100;
  localparam int FRAME = 2000;
  localparam int TOL   = 50;
  localparam int LIMIT = FRAME + TOL + 1;

  logic       clk_1MHz = 1'b0;
  logic       rst_n;
  logic       pwm_in;
  logic [3:0] pulse_width;
  logic       valid;
  logic       frame_err;
  logic       locked;

  pwm_decoder #(.UNIT(UNIT), .FRAME(FRAME), .TOL(TOL)) dut (
    .clk_1MHz   (clk_1MHz),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .pulse_width(pulse_width),
    .valid      (valid),
    .frame_err  (frame_err),
    .locked     (locked)
  );

  always #500 clk_1MHz = ~clk_1MHz;

  typedef struct {
    bit       is_err;
    int       pw;
    bit       lck;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Frame list: high cycles, low cycles, reset-in-high flag
  int fh[$];
  int fl[$];
  bit frst[$];

  // Reference model state (frame granularity)
  bit m_have_prev = 0;
  int m_prev_p    = 0;
  int m_prev_h    = 0;
  int m_pw        = 0;
  bit m_lock      = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input bit is_err);
    exp_t e;
    e.is_err = is_err;
    e.pw     = m_pw;
    e.lck    = m_lock;
    exp_q.push_back(e);
  endtask

  // A code of 0 means no rise at all: the previous frame's low phase grows.
  task automatic add(input int h, input int p, input bit r);
    if (h == 0) begin
      fl[fl.size()-1] = fl[fl.size()-1] + p;
    end else begin
      fh.push_back(h);
      fl.push_back(p - h);
      frst.push_back(r);
    end
  endtask

  task automatic model_frame(input int h, input int l, input bit r);
    int p;
    int n;
    int code;
    p = h + l;
    // Rise of this frame closes the previous one
    if (m_have_prev) begin
      if (m_prev_p >= FRAME - TOL && m_prev_p <= FRAME + TOL) begin
        code = (m_prev_h + UNIT / 2) / UNIT;
        if (code > 15) code = 15;
        m_pw   = code;
        m_lock = 1;
        push_exp(0);
      end else begin
        m_lock = 0;
        push_exp(1);
      end
    end
    if (r) begin
      m_have_prev = 0;
      m_pw        = 0;
      m_lock      = 0;
    end else if (h >= LIMIT) begin
      m_lock = 0;
      push_exp(1);
      m_have_prev = 0;
    end else begin
      // One zero-duty report per LIMIT cycles without a rise
      n = (p - 1) / LIMIT;
      for (int k = 0; k < n; k++) begin
        m_pw = 0;
        push_exp(0);
      end
      m_have_prev = (n == 0);
      m_prev_p    = p;
      m_prev_h    = h;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_1MHz);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_pulse_width", int'(pulse_width), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_locked", int'(locked), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports an event
  always @(negedge clk_1MHz) begin
    if (rst_n === 1'b1 && (valid === 1'b1 || frame_err === 1'b1)) begin
      check("exclusive_strobes", int'(valid && frame_err), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: valid=%0d frame_err=%0d pulse_width=%0d, none expected at t=%0t",
                 valid, frame_err, pulse_width, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_is_err", int'(frame_err), int'(mon_e.is_err));
        check("pulse_width", int'(pulse_width), mon_e.pw);
        check("locked", int'(locked), int'(mon_e.lck));
      end
    end
  end

  initial begin
    #95_000_000;
    $display("FAIL watchdog: simulation exceeded cycle budget, pending=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    int h;
    int p;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #100;
    check_reset_outputs();
    cycles(3);
    rst_n = 1'b1;
    cycles(20);

    // Steady 700/2000
    for (int i = 0; i < 3; i++) add(700, 2000, 0);
    // Rounding and period tolerance edges
    add(149, 2000, 0);
    add(150, 2000, 0);
    add(700, 1949, 0);
    add(700, 2000, 0);
    add(700, 2051, 0);
    add(700, 1950, 0);
    add(700, 2050, 0);
    // Code sweep 1..15, then 0, then 1
    for (int c = 1; c < 16; c++) add(c * UNIT, 2000, 0);
    add(0, 2000, 0);
    add(UNIT, 2000, 0);
    // Random frames around nominal period
    for (int i = 0; i < 3; i++) begin
      h = $urandom_range(1, 1800);
      p = 1930 + $urandom_range(0, 140);
      add(h, p, 0);
    end
    // Stuck high, then relock
    add(3000, 4000, 0);
    add(700, 2000, 0);
    add(700, 2000, 0);
    // Reset mid high phase, then relock
    add(700, 2000, 1);
    add(700, 2000, 0);
    add(700, 2000, 0);
    // Trailing frame ends in a zero-duty timeout
    add(700, 2800, 0);

    for (int i = 0; i < fh.size(); i++) begin
      model_frame(fh[i], fl[i], frst[i]);
      pwm_in = 1'b1;
      if (frst[i]) begin
        cycles(400);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        cycles(3);
        rst_n = 1'b1;
        cycles(fh[i] - 403);
      end else begin
        cycles(fh[i]);
      end
      pwm_in = 1'b0;
      cycles(fl[i]);
    end

    cycles(20);
    check("pending_expected_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
